// File: rtl/md_scheduler_pkg.sv
// Shared definitions for the mult/div side-sequencer: FSM encoding, decode constants and
// the status codes written to RSTATUS when the unit raises an exception.
package md_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } md_state_e;

    localparam logic [4:0] OP_MD       = 5'b00000;
    localparam logic [4:0] ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

    localparam int unsigned MAX_CYCLES_DEFAULT = 40;
    localparam logic [4:0]  RSTATUS_DEFAULT    = 5'd30;

    localparam logic [31:0] STATUS_MULT_EXC = 32'd4;
    localparam logic [31:0] STATUS_DIV_EXC  = 32'd5;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? STATUS_DIV_EXC : STATUS_MULT_EXC;
    endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// Issue, multdiv-unit and writeback-injection signals between the pipeline and the scheduler.
interface md_scheduler_if;

    logic        issue_valid;
    logic        issue_is_div;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        issue_ready;

    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;

    logic        wb_slot_free;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    modport master (
        output issue_valid, issue_is_div, issue_rd, issue_a, issue_b,
        input  issue_ready,
        input  md_a, md_b, md_ctrl_mult, md_ctrl_div,
        output md_result, md_exception, md_rdy,
        output wb_slot_free,
        input  wb_valid, wb_reg, wb_data
    );

    modport slave (
        input  issue_valid, issue_is_div, issue_rd, issue_a, issue_b,
        output issue_ready,
        output md_a, md_b, md_ctrl_mult, md_ctrl_div,
        input  md_result, md_exception, md_rdy,
        input  wb_slot_free,
        output wb_valid, wb_reg, wb_data
    );

endinterface

// File: rtl/md_hazard_cmp.sv
// Flags a D-stage instruction that touches a given pending register; register 0 never matches.
module md_hazard_cmp (
    input  logic [4:0] target,
    input  logic [4:0] src_a,
    input  logic [4:0] src_b,
    input  logic [4:0] dst,
    input  logic       src_a_used,
    input  logic       src_b_used,
    input  logic       dst_used,
    output logic       match
);

    assign match = (target != 5'd0) &&
                   ((src_a_used && (src_a == target)) ||
                    (src_b_used && (src_b == target)) ||
                    (dst_used   && (dst   == target)));

endmodule

// File: rtl/md_scheduler.sv
// Runs the multicycle mult/div unit beside the pipeline and injects its result into a free
// W-stage writeback slot, stalling D only for dependent instructions or a second mult/div.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEFAULT,
    parameter logic [4:0]  RSTATUS    = RSTATUS_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    md_scheduler_if.slave  bus,
    input  logic [4:0]     d_src_a,
    input  logic [4:0]     d_src_b,
    input  logic [4:0]     d_dst,
    input  logic           d_src_a_used,
    input  logic           d_src_b_used,
    input  logic           d_dst_used,
    input  logic           d_is_md,
    output logic           stall_d,
    output logic           busy
);

    localparam int unsigned    CntW    = $clog2(MAX_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_CYCLES - 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            is_div_q, is_div_d;
    logic            exc_q, exc_d;
    logic            hazard_rd, hazard_status;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            is_div_q <= is_div_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        a_d              = a_q;
        b_d              = b_q;
        result_d         = result_q;
        rd_d             = rd_q;
        is_div_d         = is_div_q;
        exc_d            = exc_q;
        bus.md_ctrl_mult = 1'b0;
        bus.md_ctrl_div  = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_reg       = 5'd0;
        bus.wb_data      = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (bus.issue_valid) begin
                    a_d      = bus.issue_a;
                    b_d      = bus.issue_b;
                    rd_d     = bus.issue_rd;
                    is_div_d = bus.issue_is_div;
                    exc_d    = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                // md_rdy may still be high from the previous op, so it is not looked at here.
                bus.md_ctrl_mult = ~is_div_q & ~reset;
                bus.md_ctrl_div  = is_div_q & ~reset;
                cnt_d            = '0;
                state_d          = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.md_rdy) begin
                    result_d = bus.md_result;
                    exc_d    = bus.md_exception;
                    state_d  = StDone;
                end else if (cnt_q == CntLast) begin
                    exc_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (exc_q) begin
                    bus.wb_reg   = RSTATUS;
                    bus.wb_data  = exc_code(is_div_q);
                    bus.wb_valid = bus.wb_slot_free & ~reset;
                    if (bus.wb_valid) state_d = StIdle;
                end else if (rd_q == 5'd0) begin
                    state_d = StIdle;
                end else begin
                    bus.wb_reg   = rd_q;
                    bus.wb_data  = result_q;
                    bus.wb_valid = bus.wb_slot_free & ~reset;
                    if (bus.wb_valid) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Either a mult or a div can end up writing RSTATUS, so both targets are pending.
    md_hazard_cmp u_hazard_rd (
        .target     (rd_q),
        .src_a      (d_src_a),
        .src_b      (d_src_b),
        .dst        (d_dst),
        .src_a_used (d_src_a_used),
        .src_b_used (d_src_b_used),
        .dst_used   (d_dst_used),
        .match      (hazard_rd)
    );

    md_hazard_cmp u_hazard_status (
        .target     (RSTATUS),
        .src_a      (d_src_a),
        .src_b      (d_src_b),
        .dst        (d_dst),
        .src_a_used (d_src_a_used),
        .src_b_used (d_src_b_used),
        .dst_used   (d_dst_used),
        .match      (hazard_status)
    );

    assign busy            = (state_q != StIdle);
    assign stall_d         = busy & (d_is_md | hazard_rd | hazard_status);
    assign bus.issue_ready = (state_q == StIdle);
    assign bus.md_a        = a_q;
    assign bus.md_b        = b_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: the bench plays the multdiv unit, pushes expected
// writebacks from a directed table, and a monitor pops and compares each wb_valid beat.
module tb_md_scheduler;

    localparam int unsigned MAX_CYCLES = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] d_src_a, d_src_b, d_dst;
    logic       d_src_a_used, d_src_b_used, d_dst_used, d_is_md;
    logic       stall_d, busy;

    md_scheduler_if bus ();

    md_scheduler #(
        .MAX_CYCLES (MAX_CYCLES),
        .RSTATUS    (5'd30)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .d_src_a      (d_src_a),
        .d_src_b      (d_src_b),
        .d_dst        (d_dst),
        .d_src_a_used (d_src_a_used),
        .d_src_b_used (d_src_b_used),
        .d_dst_used   (d_dst_used),
        .d_is_md      (d_is_md),
        .stall_d      (stall_d),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  reg_num;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
        logic        hang;
        int          hold;
        logic [4:0]  probe;
        logic        probe_exp;
        logic        exp_wb;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    wb_t  exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wb_cnt = 0, wb_cyc = 0, start_cyc = 0;
    int   mult_pulses = 0, div_pulses = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: counts start pulses and scores every writeback against the queue.
    always @(negedge clock) begin
        if (bus.md_ctrl_mult) begin mult_pulses++; start_cyc = cyc; end
        if (bus.md_ctrl_div)  begin div_pulses++;  start_cyc = cyc; end
        if (bus.wb_valid) begin
            wb_cnt++;
            wb_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_reg", 32'(bus.wb_reg), 32'(e.reg_num));
                check("wb_data", bus.wb_data, e.data);
            end
        end
    end

    task automatic run_op(input vec_t v);
        int  wb0, m0, d0;
        logic found, done;
        wb0 = wb_cnt; m0 = mult_pulses; d0 = div_pulses;
        check("issue_ready_idle", 32'(bus.issue_ready), 32'd1);
        if (v.exp_wb) exp_q.push_back('{reg_num: v.exp_reg, data: v.exp_data});
        bus.wb_slot_free = (v.hold == 0);
        @(posedge clock); #1;
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = v.is_div;
        bus.issue_rd     = v.rd;
        bus.issue_a      = v.a;
        bus.issue_b      = v.b;
        @(posedge clock); #1;
        bus.issue_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clock);
            if (bus.md_ctrl_mult || bus.md_ctrl_div) found = 1'b1;
        end
        check("start_seen", 32'(found), 32'd1);
        check("md_a_held", bus.md_a, v.a);
        check("md_b_held", bus.md_b, v.b);
        d_src_a = v.probe; d_src_a_used = 1'b1;
        #1 check("stall_probe", 32'(stall_d), 32'(v.probe_exp));
        d_is_md = 1'b1;
        #1 check("stall_is_md", 32'(stall_d), 32'd1);
        d_is_md = 1'b0;
        if (!v.hang) begin
            repeat (v.lat) @(posedge clock);
            #1;
            bus.md_rdy = 1'b1; bus.md_result = v.res; bus.md_exception = v.exc;
            @(posedge clock); #1;
            bus.md_rdy = 1'b0; bus.md_result = 32'hdead_beef; bus.md_exception = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clock);
                check("held_no_wb", 32'(bus.wb_valid), 32'd0);
                check("held_reg", 32'(bus.wb_reg), 32'(v.exp_reg));
                check("held_data", bus.wb_data, v.exp_data);
                @(posedge clock); #1;
            end
            bus.wb_slot_free = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < int'(MAX_CYCLES) + 20 && !done; i++) begin
            @(negedge clock);
            if (bus.wb_valid) check("stall_at_wb", 32'(stall_d), 32'(v.probe_exp));
            if (!busy) begin
                check("stall_release", 32'(stall_d), 32'd0);
                done = 1'b1;
            end
        end
        check("op_complete", 32'(done), 32'd1);
        d_src_a_used = 1'b0;
        check("wb_count", 32'(wb_cnt - wb0), 32'(v.exp_wb));
        if (v.exp_wb)
            check("wb_latency", 32'(wb_cyc - start_cyc),
                  v.hang ? 32'(MAX_CYCLES + 1) : 32'(v.lat + 1 + v.hold));
        check("mult_pulses", 32'(mult_pulses - m0), 32'(!v.is_div));
        check("div_pulses", 32'(div_pulses - d0), 32'(v.is_div));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int wb0, p0;
        //          div  rd     a       b      res    exc lat hang hold probe pexp wb reg   data
        vecs[0] = '{1'b0, 5'd5,  32'd6,   32'd7, 32'd42, 1'b0, 16, 1'b0, 0, 5'd5,  1'b1, 1'b1, 5'd5,  32'd42};
        vecs[1] = '{1'b1, 5'd9,  32'd7,   32'd0, 32'd0,  1'b1, 8,  1'b0, 0, 5'd6,  1'b0, 1'b1, 5'd30, 32'd5};
        vecs[2] = '{1'b1, 5'd12, 32'd100, 32'd7, 32'd14, 1'b0, 20, 1'b0, 3, 5'd30, 1'b1, 1'b1, 5'd12, 32'd14};
        vecs[3] = '{1'b0, 5'd0,  32'd3,   32'd3, 32'd9,  1'b0, 4,  1'b0, 0, 5'd0,  1'b0, 1'b0, 5'd0,  32'd0};
        vecs[4] = '{1'b0, 5'd7,  32'd2,   32'd9, 32'd0,  1'b0, 0,  1'b1, 0, 5'd7,  1'b1, 1'b1, 5'd30, 32'd4};
        vecs[5] = '{1'b0, 5'd0,  32'd5,   32'd5, 32'd0,  1'b1, 3,  1'b0, 0, 5'd6,  1'b0, 1'b1, 5'd30, 32'd4};

        reset = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_is_div = 1'b0; bus.issue_rd = 5'd0;
        bus.issue_a = 32'd0; bus.issue_b = 32'd0;
        bus.md_result = 32'd0; bus.md_exception = 1'b0; bus.md_rdy = 1'b0;
        bus.wb_slot_free = 1'b1;
        d_src_a = 5'd0; d_src_b = 5'd0; d_dst = 5'd0;
        d_src_a_used = 1'b0; d_src_b_used = 1'b0; d_dst_used = 1'b0; d_is_md = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.issue_a = 32'd11; bus.issue_b = 32'd13;
        d_is_md = 1'b1;
        @(negedge clock);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall_d), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_ctrl", 32'({bus.md_ctrl_mult, bus.md_ctrl_div}), 32'd0);
        check("rst_md_a", bus.md_a, 32'd0);
        check("rst_md_b", bus.md_b, 32'd0);
        check("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        @(posedge clock); #1;
        check("rst_wins_issue", 32'(busy), 32'd0);
        reset = 1'b0; bus.issue_valid = 1'b0; d_is_md = 1'b0;

        for (int i = 0; i < 4; i++) run_op(vecs[i]);

        // Reset lands while the unit is running; nothing may be written back.
        @(posedge clock); #1;
        bus.issue_valid = 1'b1; bus.issue_is_div = 1'b0; bus.issue_rd = 5'd3;
        bus.issue_a = 32'd2; bus.issue_b = 32'd2;
        @(posedge clock); #1;
        bus.issue_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_ready", 32'(bus.issue_ready), 32'd1);
        wb0 = wb_cnt; p0 = mult_pulses + div_pulses;
        bus.md_rdy = 1'b1; bus.md_result = 32'd4;
        repeat (6) @(negedge clock);
        bus.md_rdy = 1'b0;
        check("midrun_no_wb", 32'(wb_cnt - wb0), 32'd0);
        check("midrun_no_pulse", 32'(mult_pulses + div_pulses - p0), 32'd0);
        check("midrun_idle", 32'(busy), 32'd0);

        for (int i = 4; i < 6; i++) run_op(vecs[i]);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Sequencer that runs the multicycle multiply/divide unit off to the side of the 5-stage pipeline instead of freezing every latch while it works. It accepts a mul/div from X, latches the operands, sends the unit one start pulse, and waits for ready. It then merges the result into a free W-stage writeback slot. Meanwhile it raises a D-stage stall only for instructions that depend on the pending destination or need the unit again.

## Interface
- MAX_CYCLES, 40: watchdog limit on cycles in RUN before forcing an exception result
- RSTATUS, 30: register written on mul/div exception
- clock  in  1  master clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- issue_valid  in  1  X holds mult/div (op 00000, ALU op 00110/00111) advancing this cycle
- issue_is_div  in  1  1 = div, 0 = mult
- issue_rd  in  5  destination register
- issue_a, issue_b  in  32  bypassed operands
- issue_ready  out  1  scheduler can accept an issue this cycle
- md_a, md_b  out  32  held operands to multdiv
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses
- md_result  in  32; md_exception  in  1; md_rdy  in  1  multdiv outputs
- d_src_a, d_src_b, d_dst  in  5  D-stage register fields
- d_src_a_used, d_src_b_used, d_dst_used, d_is_md  in  1  D-stage usage flags
- stall_d  out  1  hold PC/FD and inject nop into DX
- wb_slot_free  in  1  W-stage instruction does not write the regfile this cycle
- wb_valid  out  1; wb_reg  out  5; wb_data  out  32  writeback injection
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE:
  - issue_ready = 1.
  - On issue_valid: latch issue_a/b into md_a/b, latch issue_rd and issue_is_div, go to START.
- START:
  - Assert exactly one of md_ctrl_mult/md_ctrl_div.
  - Clear the watchdog counter and go to RUN.
  - md_rdy is ignored in START, because it may still be high from the previous op.
- RUN:
  - Counter increments each cycle.
  - md_rdy = 1: latch md_result and md_exception, go to DONE.
  - Counter reaches MAX_CYCLES without md_rdy: set the exception flag, go to DONE.
- DONE, exception clear: wb_reg = latched rd, wb_data = result.
- DONE, exception set: wb_reg = RSTATUS, wb_data = 4 (mult) or 5 (div).
- DONE, writeback: wb_valid = wb_slot_free (combinational).
  - When wb_valid = 1, go to IDLE on the same edge.
  - Otherwise hold in DONE; the result stays stable.
- Destination 0 with no exception: wb_valid is never asserted, and DONE exits to IDLE unconditionally.
- stall_d = busy & (d_is_md | hazard).
  - hazard: a used D field (src a, src b, or dst) equals the pending target register, and that target is nonzero.
  - Pending target = latched rd, or RSTATUS when the op is a div or mult (either may raise the exception).
- issue_valid while not IDLE is a pipeline bug. It is ignored and the assertion checker flags it; stall_d prevents it in a correct pipeline.

## Timing
- Issue accepted at edge 0 → start pulse high during cycle 1 → RUN from cycle 2.
- Ready seen in RUN cycle k → DONE at k+1 → wb_valid in the first DONE cycle with wb_slot_free.
- Minimum issue-to-writeback: 3 cycles plus unit latency.
- stall_d releases the cycle after DONE exits; the regfile holds the value by then.
- Reset values:
  - state IDLE; counter 0.
  - md_ctrl_mult, md_ctrl_div, wb_valid, stall_d, busy = 0.
  - md_a, md_b, wb_reg, wb_data = 0.
  - issue_ready = 1.
- Reset mid-operation (any state): return to IDLE next edge, no start pulse, result discarded, no writeback.
- Reset and issue_valid in the same cycle: reset wins.

## Structure
- Shared package holds:
  - state encoding (2-bit);
  - opcode and ALU-op constants for mult/div;
  - RSTATUS codes 4 and 5.
- One sub-module: md_hazard_cmp, a combinational 3-way register-match plus zero-register mask. The FSM, counter, and latches stay in md_scheduler.

## Test plan
- mult issue, a=6, b=7, rd=5, unit ready after 16 cycles, wb_slot_free=1 → one start pulse, wb_valid once with reg 5, data 42, then IDLE.
- div 7/0 with md_exception → wb_reg=30, wb_data=5.
- Pending rd=5; D reads src_a=5 → stall_d=1 until the cycle after writeback. With src_a=6, stall_d=0. With rd=0 there is never a stall and never a writeback.
- wb_slot_free held low for 3 cycles in DONE → wb_valid waits; data stays stable; one writeback when the slot frees.
- md_rdy never asserted → after MAX_CYCLES, wb_reg=30 with data 4 (mult).
- Reset asserted in RUN → IDLE next cycle, busy=0, no wb_valid; a subsequent issue proceeds normally.
